// File: rtl/tlb_core.sv
// tlb_core: joint MIPS32-style TLB array behind the data MMU.
// Holds TLBNUM dual-page entries (4 KB pages only; mask is stored but not matched).
// Lookup and read results are registered and appear the cycle after the strobe.
// Lookups and reads in a write cycle see the pre-write entry contents.
module tlb_core #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  // lookup port
  input  logic             data_tlbReq_i,
  input  logic [18:0]      data_vpn2_i,
  input  logic             data_oddPage_i,
  input  logic [7:0]       data_asid_i,
  output logic             data_hit_o,
  output logic [IDX_W-1:0] data_index_o,
  output logic [19:0]      data_pfn_o,
  output logic [2:0]       data_c_o,
  output logic             data_d_o,
  output logic             data_v_o,
  // write port
  input  logic             w_enbale_i,
  input  logic [IDX_W-1:0] w_index_i,
  input  logic [18:0]      w_vpn2_i,
  input  logic [7:0]       w_asid_i,
  input  logic [11:0]      w_mask_i,
  input  logic             w_g_i,
  input  logic [19:0]      w_pfn0_i,
  input  logic [4:0]       w_flags0_i,
  input  logic [19:0]      w_pfn1_i,
  input  logic [4:0]       w_flags1_i,
  // read port
  input  logic             r_enbale_i,
  input  logic [IDX_W-1:0] r_index_i,
  output logic [18:0]      r_vpn2_o,
  output logic [7:0]       r_asid_o,
  output logic [11:0]      r_mask_o,
  output logic             r_g_o,
  output logic [19:0]      r_pfn0_o,
  output logic [4:0]       r_flags0_o,
  output logic [19:0]      r_pfn1_o,
  output logic [4:0]       r_flags1_o
);

  // entry storage
  logic [TLBNUM-1:0] written_q, written_d;
  logic [TLBNUM-1:0] g_q, g_d;
  logic [18:0]       vpn2_q   [TLBNUM];
  logic [18:0]       vpn2_d   [TLBNUM];
  logic [7:0]        asid_q   [TLBNUM];
  logic [7:0]        asid_d   [TLBNUM];
  logic [11:0]       mask_q   [TLBNUM];
  logic [11:0]       mask_d   [TLBNUM];
  logic [19:0]       pfn0_q   [TLBNUM];
  logic [19:0]       pfn0_d   [TLBNUM];
  logic [4:0]        flags0_q [TLBNUM];
  logic [4:0]        flags0_d [TLBNUM];
  logic [19:0]       pfn1_q   [TLBNUM];
  logic [19:0]       pfn1_d   [TLBNUM];
  logic [4:0]        flags1_q [TLBNUM];
  logic [4:0]        flags1_d [TLBNUM];

  // lookup result registers
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [19:0]      pfn_q, pfn_d;
  logic [4:0]       flags_q, flags_d;

  // read result registers
  logic [18:0] rd_vpn2_q, rd_vpn2_d;
  logic [7:0]  rd_asid_q, rd_asid_d;
  logic [11:0] rd_mask_q, rd_mask_d;
  logic        rd_g_q, rd_g_d;
  logic [19:0] rd_pfn0_q, rd_pfn0_d;
  logic [4:0]  rd_flags0_q, rd_flags0_d;
  logic [19:0] rd_pfn1_q, rd_pfn1_d;
  logic [4:0]  rd_flags1_q, rd_flags1_d;

  logic [TLBNUM-1:0] match;
  logic [IDX_W-1:0]  match_idx;
  logic [19:0]       sel_pfn;
  logic [4:0]        sel_flags;

  // associative compare; descending scan so the lowest matching index wins
  always_comb begin
    match     = '0;
    match_idx = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      match[i] = written_q[i] && (vpn2_q[i] == data_vpn2_i) &&
                 (g_q[i] || (asid_q[i] == data_asid_i));
    end
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (match[i]) match_idx = IDX_W'(i);
    end
  end

  // page select; a miss forces pfn and flags to zero
  always_comb begin
    sel_pfn   = '0;
    sel_flags = '0;
    if (|match) begin
      sel_pfn   = data_oddPage_i ? pfn1_q[match_idx]   : pfn0_q[match_idx];
      sel_flags = data_oddPage_i ? flags1_q[match_idx] : flags0_q[match_idx];
    end
  end

  // lookup result next-state: capture on request, otherwise hold
  always_comb begin
    hit_d   = hit_q;
    index_d = index_q;
    pfn_d   = pfn_q;
    flags_d = flags_q;
    if (data_tlbReq_i) begin
      hit_d   = |match;
      index_d = match_idx;
      pfn_d   = sel_pfn;
      flags_d = sel_flags;
    end
  end

  // read result next-state: capture on read strobe, otherwise hold
  always_comb begin
    rd_vpn2_d   = rd_vpn2_q;
    rd_asid_d   = rd_asid_q;
    rd_mask_d   = rd_mask_q;
    rd_g_d      = rd_g_q;
    rd_pfn0_d   = rd_pfn0_q;
    rd_flags0_d = rd_flags0_q;
    rd_pfn1_d   = rd_pfn1_q;
    rd_flags1_d = rd_flags1_q;
    if (r_enbale_i) begin
      rd_vpn2_d   = vpn2_q[r_index_i];
      rd_asid_d   = asid_q[r_index_i];
      rd_mask_d   = mask_q[r_index_i];
      rd_g_d      = g_q[r_index_i];
      rd_pfn0_d   = pfn0_q[r_index_i];
      rd_flags0_d = flags0_q[r_index_i];
      rd_pfn1_d   = pfn1_q[r_index_i];
      rd_flags1_d = flags1_q[r_index_i];
    end
  end

  // entry next-state: the write strobe replaces one whole entry
  always_comb begin
    written_d = written_q;
    g_d       = g_q;
    vpn2_d    = vpn2_q;
    asid_d    = asid_q;
    mask_d    = mask_q;
    pfn0_d    = pfn0_q;
    flags0_d  = flags0_q;
    pfn1_d    = pfn1_q;
    flags1_d  = flags1_q;
    if (w_enbale_i) begin
      written_d[w_index_i] = 1'b1;
      g_d[w_index_i]       = w_g_i;
      vpn2_d[w_index_i]    = w_vpn2_i;
      asid_d[w_index_i]    = w_asid_i;
      mask_d[w_index_i]    = w_mask_i;
      pfn0_d[w_index_i]    = w_pfn0_i;
      flags0_d[w_index_i]  = w_flags0_i;
      pfn1_d[w_index_i]    = w_pfn1_i;
      flags1_d[w_index_i]  = w_flags1_i;
    end
  end

  // all state registers; reset invalidates every entry and clears outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written_q   <= '0;
      g_q         <= '0;
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i]   <= '0;
        asid_q[i]   <= '0;
        mask_q[i]   <= '0;
        pfn0_q[i]   <= '0;
        flags0_q[i] <= '0;
        pfn1_q[i]   <= '0;
        flags1_q[i] <= '0;
      end
      hit_q       <= 1'b0;
      index_q     <= '0;
      pfn_q       <= '0;
      flags_q     <= '0;
      rd_vpn2_q   <= '0;
      rd_asid_q   <= '0;
      rd_mask_q   <= '0;
      rd_g_q      <= 1'b0;
      rd_pfn0_q   <= '0;
      rd_flags0_q <= '0;
      rd_pfn1_q   <= '0;
      rd_flags1_q <= '0;
    end else begin
      written_q   <= written_d;
      g_q         <= g_d;
      vpn2_q      <= vpn2_d;
      asid_q      <= asid_d;
      mask_q      <= mask_d;
      pfn0_q      <= pfn0_d;
      flags0_q    <= flags0_d;
      pfn1_q      <= pfn1_d;
      flags1_q    <= flags1_d;
      hit_q       <= hit_d;
      index_q     <= index_d;
      pfn_q       <= pfn_d;
      flags_q     <= flags_d;
      rd_vpn2_q   <= rd_vpn2_d;
      rd_asid_q   <= rd_asid_d;
      rd_mask_q   <= rd_mask_d;
      rd_g_q      <= rd_g_d;
      rd_pfn0_q   <= rd_pfn0_d;
      rd_flags0_q <= rd_flags0_d;
      rd_pfn1_q   <= rd_pfn1_d;
      rd_flags1_q <= rd_flags1_d;
    end
  end

  assign data_hit_o   = hit_q;
  assign data_index_o = index_q;
  assign data_pfn_o   = pfn_q;
  assign data_c_o     = flags_q[4:2];
  assign data_d_o     = flags_q[1];
  assign data_v_o     = flags_q[0];

  assign r_vpn2_o   = rd_vpn2_q;
  assign r_asid_o   = rd_asid_q;
  assign r_mask_o   = rd_mask_q;
  assign r_g_o      = rd_g_q;
  assign r_pfn0_o   = rd_pfn0_q;
  assign r_flags0_o = rd_flags0_q;
  assign r_pfn1_o   = rd_pfn1_q;
  assign r_flags1_o = rd_flags1_q;

endmodule

// File: tb/tb_tlb_core.sv
// tb_tlb_core: directed vectors with hand-computed expectations for tlb_core.
module tb_tlb_core;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             data_tlbReq_i = 1'b0;
  logic [18:0]      data_vpn2_i = '0;
  logic             data_oddPage_i = 1'b0;
  logic [7:0]       data_asid_i = '0;
  logic             data_hit_o;
  logic [IDX_W-1:0] data_index_o;
  logic [19:0]      data_pfn_o;
  logic [2:0]       data_c_o;
  logic             data_d_o;
  logic             data_v_o;
  logic             w_enbale_i = 1'b0;
  logic [IDX_W-1:0] w_index_i = '0;
  logic [18:0]      w_vpn2_i = '0;
  logic [7:0]       w_asid_i = '0;
  logic [11:0]      w_mask_i = '0;
  logic             w_g_i = 1'b0;
  logic [19:0]      w_pfn0_i = '0;
  logic [4:0]       w_flags0_i = '0;
  logic [19:0]      w_pfn1_i = '0;
  logic [4:0]       w_flags1_i = '0;
  logic             r_enbale_i = 1'b0;
  logic [IDX_W-1:0] r_index_i = '0;
  logic [18:0]      r_vpn2_o;
  logic [7:0]       r_asid_o;
  logic [11:0]      r_mask_o;
  logic             r_g_o;
  logic [19:0]      r_pfn0_o;
  logic [4:0]       r_flags0_o;
  logic [19:0]      r_pfn1_o;
  logic [4:0]       r_flags1_o;

  int n_total = 0;
  int n_bad   = 0;

  tlb_core #(.TLBNUM(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .data_tlbReq_i(data_tlbReq_i), .data_vpn2_i(data_vpn2_i),
    .data_oddPage_i(data_oddPage_i), .data_asid_i(data_asid_i),
    .data_hit_o(data_hit_o), .data_index_o(data_index_o),
    .data_pfn_o(data_pfn_o), .data_c_o(data_c_o),
    .data_d_o(data_d_o), .data_v_o(data_v_o),
    .w_enbale_i(w_enbale_i), .w_index_i(w_index_i), .w_vpn2_i(w_vpn2_i),
    .w_asid_i(w_asid_i), .w_mask_i(w_mask_i), .w_g_i(w_g_i),
    .w_pfn0_i(w_pfn0_i), .w_flags0_i(w_flags0_i),
    .w_pfn1_i(w_pfn1_i), .w_flags1_i(w_flags1_i),
    .r_enbale_i(r_enbale_i), .r_index_i(r_index_i),
    .r_vpn2_o(r_vpn2_o), .r_asid_o(r_asid_o), .r_mask_o(r_mask_o),
    .r_g_o(r_g_o), .r_pfn0_o(r_pfn0_o), .r_flags0_o(r_flags0_o),
    .r_pfn1_o(r_pfn1_o), .r_flags1_o(r_flags1_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change on negedge; the following posedge consumes them
  task automatic set_write(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                           input logic [11:0] mask, input logic g,
                           input logic [19:0] p0, input logic [4:0] f0,
                           input logic [19:0] p1, input logic [4:0] f1);
    w_enbale_i = 1'b1; w_index_i = idx; w_vpn2_i = vpn2; w_asid_i = asid;
    w_mask_i = mask; w_g_i = g; w_pfn0_i = p0; w_flags0_i = f0;
    w_pfn1_i = p1; w_flags1_i = f1;
  endtask

  task automatic set_lookup(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
    data_tlbReq_i = 1'b1; data_vpn2_i = vpn2; data_asid_i = asid; data_oddPage_i = odd;
  endtask

  task automatic step();
    @(negedge clk);
    data_tlbReq_i = 1'b0;
    w_enbale_i    = 1'b0;
    r_enbale_i    = 1'b0;
  endtask

  task automatic chk_lookup(input string tag, input logic hit, input logic [3:0] idx,
                            input logic [19:0] pfn, input logic [2:0] c,
                            input logic d, input logic v);
    chk({tag, ".hit"}, 32'(data_hit_o), 32'(hit));
    chk({tag, ".idx"}, 32'(data_index_o), 32'(idx));
    chk({tag, ".pfn"}, 32'(data_pfn_o), 32'(pfn));
    chk({tag, ".cdv"}, 32'({data_c_o, data_d_o, data_v_o}), 32'({c, d, v}));
  endtask

  initial begin
    // reset held from time 0
    #12;
    chk_lookup("rst_hold", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // all-zero key must miss on a freshly reset array
    set_lookup(19'h0, 8'h00, 1'b0);
    step();
    chk_lookup("zero_key", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);

    // entry 3, non-global ASID 5
    set_write(4'd3, 19'h00400, 8'h05, 12'h5A5, 1'b0, 20'h12345, 5'b01111, 20'h0ABCD, 5'b01001);
    step();
    set_lookup(19'h00400, 8'h05, 1'b1);
    step();
    chk_lookup("e3_odd", 1'b1, 4'd3, 20'h0ABCD, 3'b010, 1'b0, 1'b1);

    // no request: outputs hold even though the key would miss
    data_vpn2_i = 19'h7FFFF;
    step();
    chk_lookup("hold", 1'b1, 4'd3, 20'h0ABCD, 3'b010, 1'b0, 1'b1);

    set_lookup(19'h00400, 8'h06, 1'b1);
    step();
    chk_lookup("asid_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);

    // read entry 3 back
    r_enbale_i = 1'b1; r_index_i = 4'd3;
    step();
    chk("rd_vpn2", 32'(r_vpn2_o), 32'h00400);
    chk("rd_asid", 32'(r_asid_o), 32'h05);
    chk("rd_mask", 32'(r_mask_o), 32'h5A5);
    chk("rd_g", 32'(r_g_o), 32'h0);
    chk("rd_pfn0", 32'(r_pfn0_o), 32'h12345);
    chk("rd_flags0", 32'(r_flags0_o), 32'h0F);
    chk("rd_pfn1", 32'(r_pfn1_o), 32'h0ABCD);
    chk("rd_flags1", 32'(r_flags1_o), 32'h09);

    // read strobe low: hold despite a different index
    r_index_i = 4'd0;
    step();
    chk("rd_hold_vpn2", 32'(r_vpn2_o), 32'h00400);
    chk("rd_hold_pfn0", 32'(r_pfn0_o), 32'h12345);

    // rewrite entry 3 as global
    set_write(4'd3, 19'h00400, 8'h05, 12'h5A5, 1'b1, 20'h12345, 5'b01111, 20'h0ABCD, 5'b01001);
    step();
    set_lookup(19'h00400, 8'h06, 1'b0);
    step();
    chk_lookup("global_even", 1'b1, 4'd3, 20'h12345, 3'b011, 1'b1, 1'b1);

    // duplicate entries 7 then 2: lowest index wins
    set_write(4'd7, 19'h00010, 8'h01, 12'h0, 1'b0, 20'h77777, 5'b00001, 20'h77770, 5'b00011);
    step();
    set_write(4'd2, 19'h00010, 8'h01, 12'h0, 1'b0, 20'h22222, 5'b10101, 20'h22220, 5'b00011);
    step();
    set_lookup(19'h00010, 8'h01, 1'b0);
    step();
    chk_lookup("dup_low", 1'b1, 4'd2, 20'h22222, 3'b101, 1'b0, 1'b1);

    // same-cycle write + lookup + read of entry 5 sees old contents
    set_write(4'd5, 19'h00020, 8'h09, 12'h0, 1'b0, 20'h55555, 5'b00111, 20'h55550, 5'b00011);
    set_lookup(19'h00020, 8'h09, 1'b0);
    r_enbale_i = 1'b1; r_index_i = 4'd5;
    step();
    chk_lookup("rbw_lookup", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    chk("rbw_read", 32'(r_vpn2_o), 32'h0);
    set_lookup(19'h00020, 8'h09, 1'b0);
    step();
    chk_lookup("after_w5", 1'b1, 4'd5, 20'h55555, 3'b001, 1'b1, 1'b1);

    // lookup and read together; read targets a never-written entry
    set_lookup(19'h00400, 8'h33, 1'b1);
    r_enbale_i = 1'b1; r_index_i = 4'd9;
    step();
    chk_lookup("dual_lk", 1'b1, 4'd3, 20'h0ABCD, 3'b010, 1'b0, 1'b1);
    chk("unwritten_vpn2", 32'(r_vpn2_o), 32'h0);
    chk("unwritten_pfn1", 32'(r_pfn1_o), 32'h0);

    // set up nonzero read outputs then reset mid-cycle
    r_enbale_i = 1'b1; r_index_i = 4'd3;
    set_lookup(19'h00400, 8'h05, 1'b1);
    step();
    chk("pre_rst_hit", 32'(data_hit_o), 32'h1);
    chk("pre_rst_rd", 32'(r_vpn2_o), 32'h00400);
    set_lookup(19'h00400, 8'h05, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_lookup("async_rst", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    chk("async_rst_rd", 32'(r_vpn2_o), 32'h0);
    chk("async_rst_rdf", 32'(r_flags1_o), 32'h0);
    @(negedge clk);
    data_tlbReq_i = 1'b0;
    rst = 1'b1;
    set_lookup(19'h00400, 8'h05, 1'b1);
    step();
    chk_lookup("post_rst", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb_core.md
Name: tlb_core

Overview:
- Joint MIPS32-style TLB array directly downstream of the data MMU.
- Serves three interfaces:
  - the MMU's map/probe lookup port (vpn2/oddPage/asid in, hit/index/pfn/flags out);
  - the TLBWI/TLBWR write port;
  - the TLBR read port.
- Lookup and read results are registered. They are valid the cycle after the request, which is when the MMU consumes them (mapReq / DMMU_TLBRwrite_o timing).
- Only 4 KB pages are supported. Mask is stored and read back but never used in matching.

Parameters:
- TLBNUM, 16, number of entries (power of two, 2..32).
- IDX_W, 4, index width = log2(TLBNUM).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; all state cleared while low.
- data_tlbReq_i  in  1  lookup strobe; capture search result this cycle.
- data_vpn2_i  in  19  lookup VA[31:13].
- data_oddPage_i  in  1  lookup VA[12]; selects page 0/1.
- data_asid_i  in  8  lookup ASID.
- data_hit_o  out  1  registered: match found.
- data_index_o  out  IDX_W  registered: matching entry index.
- data_pfn_o  out  20  registered: PFN of selected page.
- data_c_o  out  3  registered: cache attribute of selected page.
- data_d_o  out  1  registered: dirty bit of selected page.
- data_v_o  out  1  registered: valid bit of selected page.
- w_enbale_i  in  1  write strobe.
- w_index_i  in  IDX_W  write target entry.
- w_vpn2_i  in  19  write VPN2.
- w_asid_i  in  8  write ASID.
- w_mask_i  in  12  write PageMask (stored only).
- w_g_i  in  1  write global bit.
- w_pfn0_i  in  20  write PFN0.
- w_flags0_i  in  5  write {C[2:0],D,V} for page 0.
- w_pfn1_i  in  20  write PFN1.
- w_flags1_i  in  5  write {C[2:0],D,V} for page 1.
- r_enbale_i  in  1  read strobe.
- r_index_i  in  IDX_W  read entry.
- r_vpn2_o  out  19  registered read VPN2.
- r_asid_o  out  8  registered read ASID.
- r_mask_o  out  12  registered read mask.
- r_g_o  out  1  registered read G.
- r_pfn0_o  out  20  registered read PFN0.
- r_flags0_o  out  5  registered read flags0.
- r_pfn1_o  out  20  registered read PFN1.
- r_flags1_o  out  5  registered read flags1.

Behaviour:
- Reset (rst low, asynchronous):
  - all entry fields cleared to 0;
  - every per-entry "written" bit cleared;
  - every output register cleared to 0 (data_hit_o=0).
- Entry match (combinational, in cycle T): entry i matches iff
  - written[i]=1, and
  - vpn2[i]==data_vpn2_i, and
  - g[i]=1 or asid[i]==data_asid_i.
  - A never-written entry never matches, even for all-zero keys.
- Lookup latency is one cycle:
  - If data_tlbReq_i=1 at edge T, then at T+1 data_hit_o is the OR of the match vector.
  - data_index_o is the lowest matching index; 0 on miss.
  - pfn/c/d/v come from page (data_oddPage_i ? 1 : 0) of that entry; all 0 on miss.
- If data_tlbReq_i=0, all data_* outputs hold their previous values.
- Multiple matches (software error): the lowest index wins deterministically. No exception is raised.
- Write:
  - When w_enbale_i=1 at edge T, entry w_index_i takes all w_* fields and written[w_index_i] is set.
  - The write is visible to lookups and reads issued at T+1 onwards.
- Write and lookup/read in the same cycle, any index: the lookup/read uses pre-write contents (read-before-write).
- Read latency is one cycle:
  - When r_enbale_i=1 at edge T, the r_* outputs show entry r_index_i at T+1.
  - Otherwise the r_* outputs hold.
  - Reading a never-written entry returns all zeros.
- Lookup and read may be active in the same cycle; they are independent and both update.
- Index inputs are IDX_W bits wide, so out-of-range is impossible. No wrap logic is needed.
- Reset asserted mid-operation: outputs clear immediately. The pending result is discarded and all entries are invalidated.

Test Plan:
- Reset, then lookup with vpn2=0, asid=0, odd=0 -> next cycle: hit=0, index=0, pfn=0, c=0, d=0, v=0.
- Write index 3 with:
  - vpn2=19'h00400, asid=8'h05, g=0;
  - pfn0=20'h12345, flags0=5'b01111;
  - pfn1=20'h0ABCD, flags1=5'b01001.
  - Then lookup vpn2=19'h00400, asid=8'h05, odd=1 -> hit=1, index=3, pfn=20'h0ABCD, c=3'b010, d=0, v=1.
  - Same lookup with asid=8'h06 -> hit=0.
  - Rewrite entry 3 with g=1, then lookup asid=8'h06 -> hit=1.
- Write entries 2 and 7 with identical vpn2=19'h00010 and asid=8'h01 -> lookup returns index=2.
- Same-cycle write to entry 5 (vpn2=19'h00020) plus lookup of 19'h00020 -> result hit=0. Repeat the lookup one cycle later -> hit=1, index=5.
- Read entry 3 after the write above:
  - next cycle r_vpn2=19'h00400, r_asid=8'h05, r_pfn0=20'h12345, r_flags0=5'b01111, r_g=0;
  - with r_enbale_i low, the r_* outputs hold.
- Lookup hit (hit=1), then assert rst low mid-cycle -> outputs zero immediately. After release, a repeat lookup -> hit=0.
